// File: rtl/sd_dac_pkg.sv
// Shared constants and types for the sigma-delta DAC output stage.
// Holds the LFSR seed, its tap mask and the next-state helper.
package sd_dac_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 (1-based), i.e. bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [15:0] sample_t;
  typedef logic [5:0]  dac_code_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sd_lfsr.sv
// 16-bit Fibonacci LFSR used as the dither source of sigma_delta_dac.
// Advances every clk and restarts from LFSR_SEED on reset.
module sd_lfsr
  import sd_dac_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= LFSR_SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/sigma_delta_dac.sv
// Sample-rate hold stage plus first-order error-feedback quantizer for a 6-bit R2R DAC.
// Define SD_DITHER_EN to add LFSR dither on the low residual bits.
module sigma_delta_dac
  import sd_dac_pkg::*;
#(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_BITS    = 6,
  parameter int SAMPLE_DIV  = 50,
  parameter int DITHER_BITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IN_WIDTH-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                underrun_clr,
  output logic [OUT_BITS-1:0] dac_out,
  output logic                sample_tick,
  output logic                underrun
);

  localparam int RW    = IN_WIDTH - OUT_BITS;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic [IN_WIDTH-1:0] pending, pending_d;
  logic                pending_full, pending_full_d;
  logic [IN_WIDTH-1:0] hold, hold_d;
  logic [RW-1:0]       err, err_d;
  logic [OUT_BITS-1:0] dac_d;
  logic                underrun_d;
  logic                tick, transfer;
  logic [IN_WIDTH:0]   sum;
  logic [DITHER_BITS-1:0] dither_lsbs;

`ifdef SD_DITHER_EN
  logic [15:0] lfsr_q;

  sd_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (lfsr_q)
  );

  assign dither_lsbs = lfsr_q[DITHER_BITS-1:0];
`else
  assign dither_lsbs = '0;
`endif

  // Handshake: a sample moves when sample_valid && sample_ready at a rising clk edge;
  // sample_ready is a registered !pending_full, so it is low in reset and the cycle after.
  always_comb begin
    transfer       = sample_valid && sample_ready;
    tick           = (div_cnt == '0);
    pending_d      = pending;
    pending_full_d = pending_full;
    hold_d         = hold;
    underrun_d     = underrun_clr ? 1'b0 : underrun;
    if (tick) begin
      if (pending_full) begin
        hold_d         = pending;
        pending_full_d = transfer;
        if (transfer) begin
          pending_d = sample_in;
        end
      end else if (transfer) begin
        hold_d = sample_in;
      end else begin
        underrun_d = 1'b1;
      end
    end else if (transfer) begin
      pending_d      = sample_in;
      pending_full_d = 1'b1;
    end
  end

  // Carry out of the sum would wrap the code to 0; clamp instead and keep the old error.
  always_comb begin
    sum = {1'b0, hold}
        + {{(OUT_BITS + 1){1'b0}}, err}
        + {{(IN_WIDTH + 1 - DITHER_BITS){1'b0}}, dither_lsbs};
    if (sum[IN_WIDTH]) begin
      dac_d = '1;
      err_d = err;
    end else begin
      dac_d = sum[IN_WIDTH-1:RW];
      err_d = sum[RW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt      <= DIV_RELOAD;
      pending      <= '0;
      pending_full <= 1'b0;
      sample_ready <= 1'b0;
      hold         <= '0;
      err          <= '0;
      dac_out      <= '0;
      sample_tick  <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      div_cnt      <= tick ? DIV_RELOAD : div_cnt - 1'b1;
      pending      <= pending_d;
      pending_full <= pending_full_d;
      sample_ready <= !pending_full_d;
      hold         <= hold_d;
      err          <= err_d;
      dac_out      <= dac_d;
      sample_tick  <= tick;
      underrun     <= underrun_d;
    end
  end

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Directed self-checking bench for sigma_delta_dac with SAMPLE_DIV=4.
// Expected DAC codes are queued as stimulus is applied and compared cycle by cycle.
module tb_sigma_delta_dac;

  logic        clk;
  logic        reset_n;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        underrun_clr;
  logic [5:0]  dac_out;
  logic        sample_tick;
  logic        underrun;

  int checks   = 0;
  int failures = 0;
  int dac_sum  = 0;
  logic [5:0] exp_q[$];

  sigma_delta_dac #(
    .IN_WIDTH    (16),
    .OUT_BITS    (6),
    .SAMPLE_DIV  (4),
    .DITHER_BITS (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .underrun_clr (underrun_clr),
    .dac_out      (dac_out),
    .sample_tick  (sample_tick),
    .underrun     (underrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_dac(input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // One queued expectation per falling edge.
  task automatic drain();
    logic [5:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      dac_sum += int'(dac_out);
      chk("dac", {26'd0, dac_out}, {26'd0, e});
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 20);
    chk("tick_seen", {31'd0, sample_tick}, 32'd1);
  endtask

  initial begin
    int n;
    int m;
    reset_n      = 1'b0;
    sample_in    = 16'h0000;
    sample_valid = 1'b0;
    underrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dac", {26'd0, dac_out}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_ready", {31'd0, sample_ready}, 32'd0);
    chk("rst_tick", {31'd0, sample_tick}, 32'd0);
    reset_n = 1'b1;

`ifdef SD_DITHER_EN
    sample_in    = 16'h8000;
    sample_valid = 1'b1;
    wait_tick(n);
    wait_tick(n);
    dac_sum = 0;
    repeat (4096) begin
      @(negedge clk);
      dac_sum += int'(dac_out);
    end
    chk("dither_mean_lo", {31'd0, dac_sum >= 31 * 4096}, 32'd1);
    chk("dither_mean_hi", {31'd0, dac_sum <= 33 * 4096}, 32'd1);
    chk("dither_underrun", {31'd0, underrun}, 32'd0);
`else
    // first tick with nothing offered is a miss; hold stays 0
    wait_tick(n);
    chk("underrun_first_tick", {31'd0, underrun}, 32'd1);
    chk("hold_zero", {26'd0, dac_out}, 32'd0);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("underrun_clr0", {31'd0, underrun}, 32'd0);

    // constant mid-scale
    sample_in    = 16'h8000;
    sample_valid = 1'b1;
    wait_tick(n);
    chk("latency_old_hold", {26'd0, dac_out}, 32'd0);
    push_dac(6'd32, 6);
    drain();
    chk("midscale_underrun", {31'd0, underrun}, 32'd0);

    // half-LSB: codes alternate 32/33
    sample_in = 16'h8200;
    wait_tick(n);
    wait_tick(n);
    chk("half_lsb_prev", {26'd0, dac_out}, 32'd32);
    dac_sum = 0;
    for (int i = 0; i < 4; i++) begin
      push_dac(6'd32, 1);
      push_dac(6'd33, 1);
    end
    drain();
    chk("half_lsb_sum", dac_sum, 32'd260);

    // full scale saturates, never wraps to 0
    sample_in = 16'hFFFF;
    wait_tick(n);
    wait_tick(n);
    push_dac(6'd63, 8);
    drain();

    // underrun: stop offering samples for two ticks
    wait_tick(n);
    sample_valid = 1'b0;
    wait_tick(n);
    chk("underrun_set", {31'd0, underrun}, 32'd1);
    push_dac(6'd63, 1);
    drain();
    underrun_clr = 1'b1;
    wait_tick(n);
    chk("underrun_set_wins", {31'd0, underrun}, 32'd1);
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("underrun_cleared", {31'd0, underrun}, 32'd0);

    // back-to-back A then B
    sample_in    = 16'h1000;
    sample_valid = 1'b1;
    @(negedge clk);
    chk("ready_drop", {31'd0, sample_ready}, 32'd0);
    sample_in = 16'h2000;
    wait_tick(m);
    chk("ready_after_tick", {31'd0, sample_ready}, 32'd1);
    chk("hold_before_a", {26'd0, dac_out}, 32'd63);
    push_dac(6'd4, 4);
    drain();
    chk("tick_b", {31'd0, sample_tick}, 32'd1);
    sample_valid = 1'b0;
    push_dac(6'd8, 1);
    drain();

    // bypass: sample offered exactly on a tick with pending empty
    repeat (2) @(negedge clk);
    sample_in    = 16'h3000;
    sample_valid = 1'b1;
    wait_tick(n);
    chk("bypass_no_underrun", {31'd0, underrun}, 32'd0);
    chk("bypass_ready", {31'd0, sample_ready}, 32'd1);
    sample_in = 16'h8200;
    push_dac(6'd12, 1);
    drain();

    // async reset in the middle of operation, with underrun pending
    wait_tick(n);
    sample_valid = 1'b0;
    wait_tick(n);
    chk("pre_reset_underrun", {31'd0, underrun}, 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dac_out != 6'd33 && n < 4);
    chk("pre_reset_dac33", {26'd0, dac_out}, 32'd33);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_dac", {26'd0, dac_out}, 32'd0);
    chk("async_rst_underrun", {31'd0, underrun}, 32'd0);
    chk("async_rst_ready", {31'd0, sample_ready}, 32'd0);
    @(negedge clk);
    reset_n      = 1'b1;
    sample_in    = 16'h8000;
    sample_valid = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {31'd0, sample_ready}, 32'd1);
    wait_tick(m);
    chk("first_tick_latency", 1 + m, 32'd4);
    chk("post_reset_underrun", {31'd0, underrun}, 32'd0);
    push_dac(6'd32, 2);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
